// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA timing generator: counts active pixels, reads the
// framebuffer and re-aligns sync/de with the returned colour. Optional macro:
// VGA_PIXEL_FETCH_TEST_PATTERN_EN replaces framebuffer colour with vertical bars.
module vga_pixel_fetch #(
  parameter int H_PIX       = 640,
  parameter int V_PIX       = 480,
  parameter int SCALE_SHIFT = 1,
  parameter int FB_W        = H_PIX >> SCALE_SHIFT,
  parameter int FB_H        = V_PIX >> SCALE_SHIFT,
  parameter int ADDR_W      = $clog2(FB_W * FB_H),
  parameter int PIX_W       = 12,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_i,
  input  logic              vs_i,
  input  logic              hs_valid_i,
  input  logic              vs_valid_i,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic              fb_rd_o,
  input  logic [PIX_W-1:0]  fb_data_i,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic [PIX_W-1:0]  rgb_o,
  output logic              frame_start_o
);

  localparam int L  = RD_LAT + 2;
  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

  localparam logic [XW-1:0]     X_LAST   = XW'(H_PIX - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(V_PIX - 1);
  localparam logic [YW-1:0]     Y_MASK   = YW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [YW-1:0]     y_inc;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_next;
  logic              hs_valid_prev;
  logic              armed;
  logic              active;
  logic              show;
  logic              line_end;
  logic              frame_first;

  logic [L-1:0]      hs_pipe;
  logic [L-1:0]      vs_pipe;
  logic [L-1:0]      de_pipe;
  logic [L-1:0]      fs_pipe;
  logic [PIX_W-1:0]  pixel_src;

  // Display is held off after reset until a vertical blank has been seen, so a
  // reset in mid-frame never shows a torn partial frame or a stray frame start.
  always_comb begin
    active      = hs_valid_i & vs_valid_i;
    show        = active & armed;
    line_end    = hs_valid_prev & ~hs_valid_i & vs_valid_i;
    frame_first = show & (x_cnt == '0) & (y_cnt == '0);
    addr_next   = row_base + ADDR_W'(x_cnt >> SCALE_SHIFT);
    y_inc       = y_cnt + YW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      row_base      <= '0;
      hs_valid_prev <= 1'b0;
      armed         <= 1'b0;
      fb_rd_o       <= 1'b0;
      fb_addr_o     <= '0;
    end else begin
      hs_valid_prev <= hs_valid_i;
      if (!vs_valid_i) begin
        armed <= 1'b1;
      end

      if (!hs_valid_i) begin
        x_cnt <= '0;
      end else if (active && (x_cnt != X_LAST)) begin
        x_cnt <= x_cnt + XW'(1);
      end

      // Row base steps by one framebuffer line every 2^SCALE_SHIFT raster lines.
      if (!vs_valid_i) begin
        y_cnt    <= '0;
        row_base <= '0;
      end else if (line_end && (y_cnt != Y_LAST)) begin
        y_cnt <= y_inc;
        if ((y_inc & Y_MASK) == '0) begin
          row_base <= row_base + ROW_STEP;
        end
      end

      fb_rd_o <= active;
      if (active) begin
        fb_addr_o <= addr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
      fs_pipe <= '0;
    end else begin
      hs_pipe <= {hs_pipe[L-2:0], hs_i};
      vs_pipe <= {vs_pipe[L-2:0], vs_i};
      de_pipe <= {de_pipe[L-2:0], show};
      fs_pipe <= {fs_pipe[L-2:0], frame_first};
    end
  end

`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
  logic [15:0]      x_wide;
  logic [11:0]      bar_colour;
  logic [PIX_W-1:0] pat_colour;
  logic [PIX_W-1:0] pat_pipe [L-1];

  always_comb begin
    x_wide     = 16'(x_cnt);
    bar_colour = 12'h000;
    case (x_wide[9:7])
      3'd0: bar_colour = 12'hFFF;
      3'd1: bar_colour = 12'hFF0;
      3'd2: bar_colour = 12'h0FF;
      3'd3: bar_colour = 12'h0F0;
      3'd4: bar_colour = 12'hF0F;
      3'd5: bar_colour = 12'hF00;
      3'd6: bar_colour = 12'h00F;
      3'd7: bar_colour = 12'h000;
    endcase
    if ((x_cnt == '0) || (x_cnt == X_LAST) || (y_cnt == '0) || (y_cnt == Y_LAST)) begin
      bar_colour = 12'hFFF;
    end
    pat_colour = PIX_W'(bar_colour);
  end

  // Pattern colour travels alongside de so it lands on the same output cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L - 1; k++) begin
        pat_pipe[k] <= '0;
      end
    end else begin
      pat_pipe[0] <= pat_colour;
      for (int k = 1; k < L - 1; k++) begin
        pat_pipe[k] <= pat_pipe[k-1];
      end
    end
  end

  assign pixel_src = pat_pipe[L-2];
`else
  assign pixel_src = fb_data_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_o <= '0;
    end else if (de_pipe[L-2]) begin
      rgb_o <= pixel_src;
    end else begin
      rgb_o <= '0;
    end
  end

  assign hs_o          = hs_pipe[L-1];
  assign vs_o          = vs_pipe[L-1];
  assign de_o          = de_pipe[L-1];
  assign frame_start_o = fs_pipe[L-1];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized self-checking bench for vga_pixel_fetch on a reduced raster with a
// behavioural model (counts of active pixels/lines, multiply-based addressing).
module tb_vga_pixel_fetch;

  localparam int H_PIX       = 32;
  localparam int V_PIX       = 12;
  localparam int SCALE_SHIFT = 1;
  localparam int FB_W        = H_PIX >> SCALE_SHIFT;
  localparam int FB_H        = V_PIX >> SCALE_SHIFT;
  localparam int ADDR_W      = $clog2(FB_W * FB_H);
  localparam int PIX_W       = 12;
  localparam int RD_LAT      = 3;
  localparam int L           = RD_LAT + 2;
  localparam int NF          = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hs_i = 1'b1;
  logic              vs_i = 1'b1;
  logic              hs_valid_i = 1'b0;
  logic              vs_valid_i = 1'b0;
  logic [ADDR_W-1:0] fb_addr_o;
  logic              fb_rd_o;
  logic [PIX_W-1:0]  fb_data_i;
  logic              hs_o;
  logic              vs_o;
  logic              de_o;
  logic [PIX_W-1:0]  rgb_o;
  logic              frame_start_o;

  vga_pixel_fetch #(
    .H_PIX(H_PIX), .V_PIX(V_PIX), .SCALE_SHIFT(SCALE_SHIFT), .FB_W(FB_W), .FB_H(FB_H),
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .hs_i(hs_i), .vs_i(vs_i),
    .hs_valid_i(hs_valid_i), .vs_valid_i(vs_valid_i),
    .fb_addr_o(fb_addr_o), .fb_rd_o(fb_rd_o), .fb_data_i(fb_data_i),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  // Framebuffer contents: distinct non-zero colour per address.
  function automatic logic [PIX_W-1:0] fbdata(input int a);
    return PIX_W'((a * 37 + 11) & 'hFFF);
  endfunction

  // Synchronous BRAM with RD_LAT cycles from registered address to data.
  logic [PIX_W-1:0] bram [RD_LAT];
  initial begin
    for (int k = 0; k < RD_LAT; k++) bram[k] = '0;
  end
  always @(posedge clk) begin
    bram[0] <= fb_rd_o ? fbdata(int'(fb_addr_o)) : PIX_W'(12'h5A5);
    for (int k = 1; k < RD_LAT; k++) bram[k] <= bram[k-1];
  end
  assign fb_data_i = bram[RD_LAT-1];

  typedef struct {
    logic             hs;
    logic             vs;
    logic             de;
    logic             fs;
    logic [PIX_W-1:0] rgb;
  } rec_t;

  rec_t              exp_q[$];
  int                xcount;
  int                ycount;
  bit                prev_hsv;
  bit                armed_m;
  bit                exp_rd;
  logic [ADDR_W-1:0] exp_addr;
  int                n_checks = 0;
  int                n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    rec_t idle;
    idle.hs = 1'b1; idle.vs = 1'b1; idle.de = 1'b0; idle.fs = 1'b0; idle.rgb = '0;
    exp_q.delete();
    for (int k = 0; k < L - 1; k++) exp_q.push_back(idle);
    xcount = 0; ycount = 0; prev_hsv = 1'b0; armed_m = 1'b0;
    exp_rd = 1'b0; exp_addr = '0;
  endtask

  task automatic check_reset_values();
    check("rst_hs", 32'(hs_o), 32'd1);
    check("rst_vs", 32'(vs_o), 32'd1);
    check("rst_de", 32'(de_o), 32'd0);
    check("rst_rgb", 32'(rgb_o), 32'd0);
    check("rst_fs", 32'(frame_start_o), 32'd0);
    check("rst_rd", 32'(fb_rd_o), 32'd0);
    check("rst_addr", 32'(fb_addr_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit hsv, input bit vsv, input bit hs, input bit vs);
    rec_t r;
    rec_t got;
    bit   act;
    int   x;
    int   y;
    logic [ADDR_W-1:0] a;
    hs_valid_i = hsv; vs_valid_i = vsv; hs_i = hs; vs_i = vs;
    act = hsv & vsv;
    x = (xcount < H_PIX - 1) ? xcount : H_PIX - 1;
    y = (ycount < V_PIX - 1) ? ycount : V_PIX - 1;
    a = ADDR_W'((y >> SCALE_SHIFT) * FB_W + (x >> SCALE_SHIFT));
    r.hs = hs; r.vs = vs;
    r.de = act & armed_m;
    r.fs = r.de && (x == 0) && (y == 0);
    r.rgb = r.de ? fbdata(int'(a)) : '0;
    exp_q.push_back(r);
    exp_rd = act;
    if (act) exp_addr = a;
    if (!hsv) xcount = 0; else if (act) xcount++;
    if (!vsv) ycount = 0; else if (prev_hsv && !hsv) ycount++;
    prev_hsv = hsv;
    if (!vsv) armed_m = 1'b1;
    @(negedge clk);
    check("fb_rd", 32'(fb_rd_o), 32'(exp_rd));
    check("fb_addr", 32'(fb_addr_o), 32'(exp_addr));
    got = exp_q.pop_front();
    check("hs_o", 32'(hs_o), 32'(got.hs));
    check("vs_o", 32'(vs_o), 32'(got.vs));
    check("de_o", 32'(de_o), 32'(got.de));
    check("rgb_o", 32'(rgb_o), 32'(got.rgb));
    check("frame_start", 32'(frame_start_o), 32'(got.fs));
  endtask

  initial begin
    int av;
    int a;
    int pick;
    repeat (3) @(negedge clk);
    check_reset_values();
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int f = 0; f < NF; f++) begin
      pick = int'($urandom_range(0, 3));
      av = (pick == 0) ? V_PIX - 3 : (pick == 1) ? V_PIX + 2 : V_PIX;
      for (int v = 0; v < av + 5; v++) begin
        pick = int'($urandom_range(0, 19));
        if (pick < 3) a = int'($urandom_range(4, H_PIX - 1));
        else if (pick < 6) a = H_PIX + int'($urandom_range(1, 8));
        else a = H_PIX;
        for (int h = 0; h < a + 16; h++) begin
          if (f == 2 && v == 5 && h == 10) do_reset();
          step(h < a, v < av, !(h >= a + 4 && h < a + 8), !(v == av + 2 || v == av + 3));
        end
      end
      $display("frame %0d: active lines %0d, checks so far %0d", f, av, n_checks);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA timing generator: consumes its sync and valid strobes, derives pixel coordinates and generates framebuffer read addresses.
- Returns pixel colour aligned with delayed sync signals to the DAC pins.
- Supports an integer power-of-two upscale so a small framebuffer (default 320x240) fills the 640x480 raster.
- The read port is a synchronous BRAM with fixed latency.

Parameters:
- H_PIX, 640: active pixels per line.
- V_PIX, 480: active lines per frame.
- SCALE_SHIFT, 1: upscale factor is 2^SCALE_SHIFT in both axes.
- FB_W, H_PIX>>SCALE_SHIFT: framebuffer width in pixels.
- FB_H, V_PIX>>SCALE_SHIFT: framebuffer height in lines.
- ADDR_W, $clog2(FB_W*FB_H): framebuffer address width.
- PIX_W, 12: RGB444 pixel width.
- RD_LAT, 1: framebuffer read latency in cycles (1..4).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- hs_i  in  1  horizontal sync from timing generator; low = sync pulse.
- vs_i  in  1  vertical sync from timing generator; low = sync pulse.
- hs_valid_i  in  1  horizontal active region.
- vs_valid_i  in  1  vertical active region.
- fb_addr_o  out  ADDR_W  framebuffer read address.
- fb_rd_o  out  1  read enable; one read per active pixel.
- fb_data_i  in  PIX_W  read data, valid RD_LAT cycles after fb_rd_o.
- hs_o  out  1  hs_i delayed to align with rgb_o.
- vs_o  out  1  vs_i delayed to align with rgb_o.
- de_o  out  1  display enable, aligned with rgb_o.
- rgb_o  out  PIX_W  pixel colour; zero outside the active region.
- frame_start_o  out  1  one-cycle pulse, aligned with the first active pixel of a frame on rgb_o.

Behaviour:
- Reset: all outputs 0, except hs_o = 1 and vs_o = 1 (sync idle high). x_cnt, y_cnt, row_base and every delay-line stage are cleared; delay-line sync taps are cleared to 1.
- active = hs_valid_i & vs_valid_i, sampled at cycle N.
- Total latency L = RD_LAT + 2.
  - N+1: fb_addr_o/fb_rd_o registered.
  - N+1+RD_LAT: data returned on fb_data_i.
  - N+2+RD_LAT: rgb_o registered.
  - hs_o, vs_o, de_o (= active) and the frame-start flag pass through an L-deep shift register, so all outputs move together.
- x_cnt: increments on each active cycle. Clears on any cycle with hs_valid_i = 0. Saturates at H_PIX-1; extra active cycles reuse the last address.
- Line advance: on the falling edge of hs_valid_i while vs_valid_i = 1, y_cnt increments, saturating at V_PIX-1. row_base += FB_W only when the low SCALE_SHIFT bits of the new y_cnt are zero. No multiplier.
- vs_valid_i = 0 clears y_cnt and row_base on the next cycle.
- fb_addr_o = row_base + (x_cnt >> SCALE_SHIFT). Updated only when active; otherwise holds its value. fb_rd_o = registered active.
- rgb_o = fb_data_i when the delayed de = 1, else 0.
- frame_start flag = active & x_cnt == 0 & y_cnt == 0 at cycle N.
- Short lines or frames (fewer active cycles than H_PIX/V_PIX): no error; counters reset normally at the next blanking.
- Reset mid-frame: output is blank until the next vs_valid_i low→high. First addresses after that are row 0.
- If hs_valid_i is already high at reset release, the partial line is fetched from x = 0 of the current row.

Optional Feature:
- Macro: VGA_PIXEL_FETCH_TEST_PATTERN_EN.
- Defined: rgb_o is eight vertical colour bars, index = x_cnt[9:7] delayed by L, mapped to RGB444 white/yellow/cyan/green/magenta/red/blue/black. The framebuffer is still addressed, but fb_data_i is ignored. A 1-pixel white border is drawn when x_cnt ∈ {0, H_PIX-1} or y_cnt ∈ {0, V_PIX-1}.
- Undefined: rgb_o comes from framebuffer data only; no pattern logic is synthesised.

Test Plan:
- Reset release then one full 800x525 frame, RD_LAT=1: hs_o/vs_o equal inputs delayed 3 cycles; fb_rd_o asserted once per active pixel; rgb_o = 0 whenever de_o = 0.
- Framebuffer model returns data = address: line 0 rgb_o reads 0,0,1,1,…,319,319; lines 0 and 1 identical; line 2 starts at 320; last line starts at 76480.
- RD_LAT=3: latency 5 cycles; first rgb_o sample matches the frame_start_o cycle.
- 645 active cycles on one line: fb_addr_o holds at row_base+319 for the extra cycles; the next line still advances correctly.
- Assert rst at line 100, pixel 200, for 2 cycles: outputs immediately at reset values. After the next vs_valid_i rise, the first address is 0 and frame_start_o pulses once.
- With VGA_PIXEL_FETCH_TEST_PATTERN_EN: pixel x=130, y=10 gives yellow 0xFF0; x=0 gives white 0xFFF; row y=479 is all 0xFFF.
